// File: rtl/temp_buf_port_arbiter_pkg.sv
// rtl/temp_buf_port_arbiter_pkg.sv - shared types and constants for the buffer port arbiter
// Purpose: FSM state encoding, error flag bit positions and default geometry.
package temp_buf_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_FULL  = 2'd2
   } fill_state_e;

   localparam int ERR_BURST_LEN = 0;
   localparam int ERR_ADDR_SEQ  = 1;
   localparam int ERR_OVERFLOW  = 2;

   localparam int DEFAULT_BURST_LEN = 10;
   localparam int DEFAULT_DEPTH     = 100;

endpackage

// File: rtl/temp_buf_fill_tracker.sv
// rtl/temp_buf_fill_tracker.sv - frame fill count, burst framing FSM and sticky error flags
// Purpose: counts words written this frame, follows burst framing, flags errors.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   frame_clr_i       start a new frame (clears count, errors, FSM)
//   wr_en_i/wr_addr_i write stream beat and its address
//   rd_req_i/rd_addr_i read request, only checked for out-of-range addresses here
//   wr_count_o        words written this frame (saturates at DEPTH)
//   frame_full_o      wr_count_o == DEPTH
//   err_o             sticky flags: [0] burst length, [1] address order, [2] overflow / bad read
module temp_buf_fill_tracker
   import temp_buf_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 7,
   parameter int BURST_LEN  = DEFAULT_BURST_LEN,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_clr_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic                  rd_req_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [ADDR_WIDTH:0]   wr_count_o,
   output logic                  frame_full_o,
   output logic [2:0]            err_o
);

   localparam int                   BEAT_W    = $clog2(BURST_LEN + 1);
   localparam logic [ADDR_WIDTH:0]  DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN);

   fill_state_e             state_q;
   logic [BEAT_W-1:0]       beat_q;
   logic [BEAT_W-1:0]       beat_inc;
   logic [ADDR_WIDTH:0]     wr_count_q, wr_count_d, count_base;
   logic                    frame_full_q;
   logic [2:0]              err_q, err_set;
   logic                    wr_counted, addr_bad, overflow, range_bad, short_burst;

   always_comb begin
      // A write in the clear cycle is word 0 of the new frame.
      count_base  = frame_clr_i ? '0 : wr_count_q;
      wr_counted  = wr_en_i && (count_base < DEPTH_C);
      wr_count_d  = count_base + {{ADDR_WIDTH{1'b0}}, wr_counted};
      addr_bad    = wr_counted && (wr_addr_i != count_base[ADDR_WIDTH-1:0]);
      overflow    = wr_en_i && !wr_counted;
      range_bad   = rd_req_i && ({1'b0, rd_addr_i} >= DEPTH_C);
      short_burst = !frame_clr_i && (state_q == ST_BURST) && !wr_en_i;
      beat_inc    = beat_q + BEAT_W'(1);
      err_set     = 3'b000;
      err_set[ERR_BURST_LEN] = short_burst;
      err_set[ERR_ADDR_SEQ]  = addr_bad;
      err_set[ERR_OVERFLOW]  = overflow || range_bad;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         beat_q       <= '0;
         wr_count_q   <= '0;
         frame_full_q <= 1'b0;
         err_q        <= '0;
      end else begin
         wr_count_q   <= wr_count_d;
         frame_full_q <= (wr_count_d == DEPTH_C);
         if (frame_clr_i) begin
            err_q <= err_set;
            if (wr_en_i) begin
               state_q <= ST_BURST;
               beat_q  <= BEAT_W'(1);
            end else begin
               state_q <= ST_IDLE;
               beat_q  <= '0;
            end
         end else begin
            err_q <= err_q | err_set;
            case (state_q)
               ST_IDLE: begin
                  if (wr_en_i) begin
                     state_q <= ST_BURST;
                     beat_q  <= BEAT_W'(1);
                  end
               end
               ST_BURST: begin
                  if (wr_en_i) begin
                     if (beat_inc == LAST_BEAT) begin
                        beat_q  <= '0;
                        state_q <= (wr_count_d == DEPTH_C) ? ST_FULL : ST_IDLE;
                     end else begin
                        beat_q <= beat_inc;
                     end
                  end else begin
                     state_q <= ST_IDLE;
                     beat_q  <= '0;
                  end
               end
               // Writes still reach the RAM; the count saturates and err[2] is raised above.
               ST_FULL: state_q <= ST_FULL;
               default: begin
                  state_q <= ST_IDLE;
                  beat_q  <= '0;
               end
            endcase
         end
      end
   end

   assign wr_count_o   = wr_count_q;
   assign frame_full_o = frame_full_q;
   assign err_o        = err_q;

endmodule

// File: rtl/temp_buf_port_arbiter.sv
// rtl/temp_buf_port_arbiter.sv - single-port buffer RAM arbiter, write stream over reads
// Purpose: muxes the non-stallable write stream and the read requester onto one RAM port.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   frame_clr_i                    start new frame
//   wr_en_i/wr_addr_i/wr_data_i    write stream (absolute priority)
//   rd_req_i/rd_addr_i             read request, held until rd_gnt_o
//   rd_gnt_o, rd_valid_o, rd_data_o read accept and data return (1 cycle after grant)
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  RAM port, 1-cycle read latency
//   wr_count_o, frame_full_o, err_o fill status and sticky error flags
module temp_buf_port_arbiter
   import temp_buf_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int BURST_LEN  = DEFAULT_BURST_LEN,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_clr_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_req_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic                  rd_gnt_o,
   output logic                  rd_valid_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic [ADDR_WIDTH:0]   wr_count_o,
   output logic                  frame_full_o,
   output logic [2:0]            err_o
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

   logic [ADDR_WIDTH:0] wr_count;
   logic                rd_valid_q;

   temp_buf_fill_tracker #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BURST_LEN  (BURST_LEN),
      .DEPTH      (DEPTH)
   ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .frame_clr_i  (frame_clr_i),
      .wr_en_i      (wr_en_i),
      .wr_addr_i    (wr_addr_i),
      .rd_req_i     (rd_req_i),
      .rd_addr_i    (rd_addr_i),
      .wr_count_o   (wr_count),
      .frame_full_o (frame_full_o),
      .err_o        (err_o)
   );

   // Only addresses already counted this frame are readable, so a read of the
   // word being written this cycle waits until the count includes it.
   // rst gates the combinational outputs so reset quiets the RAM port at once.
   assign rd_gnt_o = !rst && rd_req_i && !wr_en_i &&
                     ({1'b0, rd_addr_i} < wr_count) &&
                     ({1'b0, rd_addr_i} < DEPTH_C);

   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (!rst) begin
         if (wr_en_i) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wr_addr_i;
            mem_wdata_o = wr_data_i;
         end else if (rd_gnt_o) begin
            mem_en_o   = 1'b1;
            mem_addr_o = rd_addr_i;
         end
      end
   end

   // Not cleared by frame_clr: a read granted in the clear cycle still returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_valid_q <= 1'b0;
      else     rd_valid_q <= rd_gnt_o;
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_valid_q ? mem_rdata_i : '0;
   assign wr_count_o = wr_count;

endmodule

// File: tb/tb_temp_buf_port_arbiter.sv
// tb/tb_temp_buf_port_arbiter.sv - scoreboard bench for temp_buf_port_arbiter
module tb_temp_buf_port_arbiter;
   import temp_buf_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_clr, wr_en, rd_req;
   logic [6:0]  wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic        rd_gnt_o, rd_valid_o, mem_en_o, mem_we_o, frame_full_o;
   logic [31:0] rd_data_o, mem_wdata_o;
   logic [31:0] mem_rdata = '0;
   logic [6:0]  mem_addr_o;
   logic [7:0]  wr_count_o;
   logic [2:0]  err_o;

   int checks = 0;
   int failures = 0;
   int we_cnt = 0;
   int reads_issued = 0;
   int reads_seen = 0;
   logic [31:0] exp_q[$];
   logic [31:0] ram [128];
   logic flag;

   always #5 clk = ~clk;

   temp_buf_port_arbiter dut (
      .clk(clk), .rst(rst), .frame_clr_i(frame_clr),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr),
      .rd_gnt_o(rd_gnt_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
      .wr_count_o(wr_count_o), .frame_full_o(frame_full_o), .err_o(err_o)
   );

   // Single-port RAM model, 1-cycle read latency.
   always @(posedge clk) begin
      if (mem_en_o && mem_we_o)  ram[mem_addr_o] <= mem_wdata_o;
      if (mem_en_o && !mem_we_o) mem_rdata <= ram[mem_addr_o];
   end

   function automatic logic [31:0] dpat(int k);
      return 32'hA500_0000 + 32'(k) * 32'h0001_0101;
   endfunction

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_words(int start, int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_addr = 7'(start + i);
         wr_data = dpat(start + i);
         step();
      end
      wr_en = 1'b0;
   endtask

   task automatic clear_frame();
      frame_clr = 1'b1;
      step();
      frame_clr = 1'b0;
   endtask

   // Monitor: pops the expected read word whenever the DUT returns data.
   always @(negedge clk) begin
      if (mem_we_o) we_cnt++;
      if (!rst && rd_valid_o) begin
         reads_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: got %0h expected no read", rd_data_o);
         end else begin
            check("rd_data", rd_data_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with active inputs: combinational outputs must still be quiet.
      rst = 1'b1; frame_clr = 1'b0; wr_en = 1'b1; wr_addr = 7'd9; wr_data = 32'hFFFF_FFFF;
      rd_req = 1'b1; rd_addr = 7'd0;
      #2;
      check("rst_mem_en", mem_en_o, 0);
      check("rst_mem_we", mem_we_o, 0);
      check("rst_rd_gnt", rd_gnt_o, 0);
      check("rst_wr_count", wr_count_o, 0);
      check("rst_err", err_o, 0);
      check("rst_frame_full", frame_full_o, 0);
      wr_en = 1'b0; rd_req = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      // One burst with a held read of address 5 (read-after-write protection).
      we_cnt = 0;
      rd_req = 1'b1; rd_addr = 7'd5;
      exp_q.push_back(dpat(5)); reads_issued++;
      flag = 1'b0;
      for (int k = 0; k < 10; k++) begin
         wr_en = 1'b1; wr_addr = 7'(k); wr_data = dpat(k);
         #3;
         if (rd_gnt_o) flag = 1'b1;
         step();
      end
      wr_en = 1'b0;
      #3;
      check("raw_no_gnt_during_burst", flag, 0);
      check("raw_gnt_after_burst", rd_gnt_o, 1);
      check("mem_we_count", we_cnt, 10);
      step();
      rd_req = 1'b0;
      check("rd_valid_latency", rd_valid_o, 1);
      check("burst_wr_count", wr_count_o, 10);
      check("burst_state", dut.u_tracker.state_q, ST_IDLE);
      check("burst_err", err_o, 0);
      step();
      // Address equal to wr_count is not yet readable.
      rd_req = 1'b1; rd_addr = 7'd10;
      #3;
      check("gnt_at_count_boundary", rd_gnt_o, 0);
      step();
      rd_req = 1'b0;
      check("rd_data_zero_idle", rd_data_o, 0);

      // Short burst.
      clear_frame();
      check("clr_wr_count", wr_count_o, 0);
      write_words(0, 7);
      step();
      check("short_err", err_o, 3'b001);
      check("short_wr_count", wr_count_o, 7);
      check("short_state", dut.u_tracker.state_q, ST_IDLE);

      // Fill to DEPTH and overflow.
      clear_frame();
      check("clr_err", err_o, 0);
      write_words(0, 100);
      check("fill_wr_count", wr_count_o, 100);
      check("fill_full", frame_full_o, 1);
      check("fill_state", dut.u_tracker.state_q, ST_FULL);
      check("fill_err", err_o, 0);
      rd_req = 1'b1; rd_addr = 7'd99;
      exp_q.push_back(dpat(99)); reads_issued++;
      #3;
      check("gnt_last_word", rd_gnt_o, 1);
      step();
      rd_req = 1'b0;
      write_words(100, 1);
      check("ovf_err", err_o, 3'b100);
      check("ovf_wr_count", wr_count_o, 100);
      check("ovf_state", dut.u_tracker.state_q, ST_FULL);

      // Address order and out-of-range read.
      clear_frame();
      wr_en = 1'b1; wr_addr = 7'd3; wr_data = 32'h1234_5678;
      step();
      wr_en = 1'b0;
      check("addr_seq_err", err_o, 3'b010);
      check("addr_seq_count", wr_count_o, 1);
      step();
      check("addr_then_short_err", err_o, 3'b011);
      rd_req = 1'b1; rd_addr = 7'd110;
      flag = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #3;
         if (rd_gnt_o) flag = 1'b1;
         step();
      end
      rd_req = 1'b0;
      check("range_no_gnt", flag, 0);
      check("range_err", err_o, 3'b111);

      // frame_clr with a write in the same cycle, then async reset mid-burst.
      frame_clr = 1'b1; wr_en = 1'b1; wr_addr = 7'd0; wr_data = dpat(0);
      step();
      frame_clr = 1'b0;
      check("clr_wr_wr_count", wr_count_o, 1);
      check("clr_wr_state", dut.u_tracker.state_q, ST_BURST);
      check("clr_wr_err", err_o, 0);
      for (int k = 1; k < 4; k++) begin
         wr_addr = 7'(k); wr_data = dpat(k);
         step();
      end
      check("mid_burst_count", wr_count_o, 4);
      wr_addr = 7'd4; rd_req = 1'b1; rd_addr = 7'd0;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_mem_en", mem_en_o, 0);
      check("async_rst_mem_we", mem_we_o, 0);
      check("async_rst_rd_gnt", rd_gnt_o, 0);
      check("async_rst_wr_count", wr_count_o, 0);
      check("async_rst_state", dut.u_tracker.state_q, ST_IDLE);
      wr_en = 1'b0; rd_req = 1'b0;
      step();
      rst = 1'b0;
      step(); step();

      check("reads_returned", reads_seen, reads_issued);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
